// File: rtl/tl_vc_pkg.sv
// Shared definitions for the transaction-layer virtual-channel push path:
// VC count, dispatcher FSM states, class-field decode and one-hot VC encode.
package tl_vc_pkg;

  localparam int NUM_VC = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } vc_state_e;

  // Extracts the 2-bit class field located at bit lsb of a (zero-extended) word.
  function automatic logic [1:0] class_decode(input logic [31:0] word, input int lsb);
    logic [31:0] shifted;
    shifted = word >> lsb;
    return shifted[1:0];
  endfunction

  function automatic logic [NUM_VC-1:0] vc_onehot(input logic [1:0] vc);
    logic [NUM_VC-1:0] oh;
    oh     = '0;
    oh[vc] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/vc_occupancy_counter.sv
// Per-VC FIFO occupancy tracker: +1 on push, -1 on pop, unchanged on both,
// and flags a pop seen while the count is already zero.
module vc_occupancy_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    case ({push_i, pop_i})
      2'b10: cnt_d = cnt_q + 1'b1;
      2'b01: begin
        if (cnt_q == '0) underflow_o = 1'b1;
        else             cnt_d       = cnt_q - 1'b1;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/vc_push_dispatcher.sv
// Write-side VC dispatcher: holds one upstream word, pushes it into the VC FIFO
// named by its class field and backpressures while that FIFO has no room.
// Optional per-VC push totals are built when DISPATCH_STATS_EN is defined.
module vc_push_dispatcher
  import tl_vc_pkg::*;
#(
  parameter int DATA_W     = 6,
  parameter int CLASS_LSB  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int STALL_W    = 8
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_VC-1:0]  almost_full,
  input  logic [NUM_VC-1:0]  pop,
  output logic [NUM_VC-1:0]  push,
  output logic [DATA_W-1:0]  data_out,
  output logic               stall,
  output logic [STALL_W-1:0] stall_cycles,
  output logic               underflow_err
`ifdef DISPATCH_STATS_EN
  ,
  output logic [NUM_VC*16-1:0] vc_push_total
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W1 = CNT_W + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = CNT_W1'(FIFO_DEPTH);

  vc_state_e            state_q, state_d;
  logic [DATA_W-1:0]    hold_q, hold_d;
  logic [NUM_VC-1:0]    push_q, push_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 stall_q, stall_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                 uf_q, uf_d;

  logic [CNT_W-1:0]     cnt [NUM_VC];
  logic [NUM_VC-1:0]    uf_evt;
  logic [1:0]           target;
  logic [CNT_W:0]       committed;
  logic                 space_ok;
  logic                 xfer;
  logic                 issue;

  assign target = class_decode(32'(hold_q), CLASS_LSB);

  // A push already on the output is not yet in cnt; include it so that
  // back-to-back words to one VC can never overrun its FIFO.
  assign committed = {1'b0, cnt[target]} + {{CNT_W{1'b0}}, push_q[target]};
  assign space_ok  = !almost_full[target] && (committed < DEPTH_LIM);

  assign in_ready = reset_L && ((state_q == IDLE) || space_ok);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (xfer) state_d = ISSUE;
      ISSUE, STALL: begin
        if (space_ok) state_d = xfer ? ISSUE : IDLE;
        else          state_d = STALL;
      end
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    issue       = (state_q != IDLE) && space_ok;
    hold_d      = xfer  ? in_data            : hold_q;
    push_d      = issue ? vc_onehot(target)  : '0;
    data_d      = issue ? hold_q             : data_q;
    stall_d     = (state_d == STALL);
    stall_cnt_d = stall_cnt_q;
    if (stall_d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    uf_d        = uf_q | (|uf_evt);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      hold_q      <= '0;
      push_q      <= '0;
      data_q      <= '0;
      stall_q     <= 1'b0;
      stall_cnt_q <= '0;
      uf_q        <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      push_q      <= push_d;
      data_q      <= data_d;
      stall_q     <= stall_d;
      stall_cnt_q <= stall_cnt_d;
      uf_q        <= uf_d;
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_occ
    vc_occupancy_counter #(
      .CNT_W (CNT_W)
    ) u_occ (
      .clk_i       (clk),
      .rst_ni      (reset_L),
      .push_i      (push_q[g]),
      .pop_i       (pop[g]),
      .count_o     (cnt[g]),
      .underflow_o (uf_evt[g])
    );
  end

`ifdef DISPATCH_STATS_EN
  for (genvar g = 0; g < NUM_VC; g++) begin : g_stats
    logic [15:0] tot_q;
    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)       tot_q <= '0;
      else if (push_q[g]) tot_q <= tot_q + 16'd1;
    end
    assign vc_push_total[16*g +: 16] = tot_q;
  end
`endif

  assign push          = push_q;
  assign data_out      = data_q;
  assign stall         = stall_q;
  assign stall_cycles  = stall_cnt_q;
  assign underflow_err = uf_q;

endmodule

// File: tb/tb_vc_push_dispatcher.sv
// Bench for vc_push_dispatcher: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the dispatch rules.
module tb_vc_push_dispatcher;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [5:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] almost_full;
  logic [3:0] pop;
  logic [3:0] push;
  logic [5:0] data_out;
  logic       stall;
  logic [7:0] stall_cycles;
  logic       underflow_err;
`ifdef DISPATCH_STATS_EN
  logic [63:0] vc_push_total;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: at most one pending word, plain integer occupancies.
  bit         m_pending;
  logic [5:0] m_hold;
  int         m_cnt [4];
  logic [3:0] m_push;
  logic [5:0] m_data;
  bit         m_stall;
  int         m_stall_cycles;
  bit         m_uf;
  bit         exp_ready;
  logic       obs_ready;

  vc_push_dispatcher #(
    .DATA_W(6), .CLASS_LSB(4), .FIFO_DEPTH(8), .STALL_W(8)
  ) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .almost_full   (almost_full),
    .pop           (pop),
    .push          (push),
    .data_out      (data_out),
    .stall         (stall),
    .stall_cycles  (stall_cycles),
    .underflow_err (underflow_err)
`ifdef DISPATCH_STATS_EN
    ,
    .vc_push_total (vc_push_total)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void m_reset();
    m_pending = 0; m_hold = '0; m_push = '0; m_data = '0;
    m_stall = 0; m_stall_cycles = 0; m_uf = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endfunction

  // Room exists when the flag is clear and occupancy including the word
  // currently being pushed stays below the depth.
  function automatic bit m_space();
    int vc;
    vc = int'(m_hold[5:4]);
    return !almost_full[vc] && ((m_cnt[vc] + int'(m_push[vc])) < 8);
  endfunction

  function automatic void m_step();
    bit         sp;
    bit         acc;
    logic [3:0] np;
    sp  = m_space();
    acc = in_valid && exp_ready;
    np  = '0;
    if (m_pending && sp) begin
      np[m_hold[5:4]] = 1'b1;
      m_data = m_hold;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_push[i] && !pop[i]) m_cnt[i]++;
      else if (pop[i] && !m_push[i]) begin
        if (m_cnt[i] == 0) m_uf = 1;
        else m_cnt[i]--;
      end
    end
    m_stall = m_pending && !sp;
    if (m_stall && m_stall_cycles < 255) m_stall_cycles++;
    m_pending = (m_pending && !sp) || acc;
    if (acc) m_hold = in_data;
    m_push = np;
  endfunction

  // One clock: drive at negedge, record ready, advance model at posedge,
  // return 1 time unit after the edge for output sampling.
  task automatic tick(input logic v, input logic [5:0] d, input logic [3:0] af,
                      input logic [3:0] p);
    @(negedge clk);
    in_valid = v; in_data = d; almost_full = af; pop = p;
    #1;
    exp_ready = m_pending ? m_space() : 1'b1;
    obs_ready = in_ready;
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; in_valid = 1'b1; in_data = 6'h05; almost_full = '0; pop = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_low: got %b want 0", in_ready); end
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_high: got %b want 1", in_ready); end
    tests_run++; if (push !== 4'b0000) begin tests_failed++; $display("FAIL reset_push: got %b want 0000", push); end
    tests_run++; if (stall !== 1'b0 || stall_cycles !== 8'd0 || underflow_err !== 1'b0)
      begin tests_failed++; $display("FAIL reset_status: stall=%b cyc=%0d uf=%b want 0/0/0", stall, stall_cycles, underflow_err); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (dut.cnt[i] !== 4'd0) begin tests_failed++; $display("FAIL reset_cnt%0d: got %0d want 0", i, dut.cnt[i]); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    logic [5:0] words [4];
    logic [3:0] exp_push [6];
    words    = '{6'h05, 6'h15, 6'h25, 6'h35};
    exp_push = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    for (int k = 0; k < 6; k++) begin
      if (k < 4) tick(1'b1, words[k], 4'b0000, 4'b0000);
      else       tick(1'b0, 6'h00, 4'b0000, 4'b0000);
      tests_run++; if (obs_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_ready[%0d]: got %b want 1", k, obs_ready); end
      tests_run++; if (push !== exp_push[k]) begin tests_failed++; $display("FAIL stream_push[%0d]: got %b want %b", k, push, exp_push[k]); end
      tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL stream_stall[%0d]: got %b want 0", k, stall); end
      if (k >= 1 && k <= 4) begin
        tests_run++; if (data_out !== words[k-1]) begin tests_failed++; $display("FAIL stream_data[%0d]: got %h want %h", k, data_out, words[k-1]); end
      end
    end
    tick(1'b0, 6'h00, 4'b0000, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (dut.cnt[i] !== 4'd0) begin tests_failed++; $display("FAIL stream_drain_cnt%0d: got %0d want 0", i, dut.cnt[i]); end
    end
    tests_run++; if (underflow_err !== 1'b0) begin tests_failed++; $display("FAIL stream_uf: got %b want 0", underflow_err); end
  endtask

  task automatic test_backpressure();
    tick(1'b1, 6'h21, 4'b0100, 4'b0000);
    tests_run++; if (obs_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_accept_ready: got %b want 1", obs_ready); end
    for (int k = 1; k <= 5; k++) begin
      tick(1'b0, 6'h00, 4'b0100, 4'b0000);
      tests_run++; if (obs_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready[%0d]: got %b want 0", k, obs_ready); end
      tests_run++; if (stall !== 1'b1 || push !== 4'b0000)
        begin tests_failed++; $display("FAIL bp_stall[%0d]: stall=%b push=%b want 1/0000", k, stall, push); end
      tests_run++; if (stall_cycles !== 8'(k)) begin tests_failed++; $display("FAIL bp_cycles[%0d]: got %0d want %0d", k, stall_cycles, k); end
    end
    tick(1'b0, 6'h00, 4'b0000, 4'b0000);
    tests_run++; if (obs_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b want 1", obs_ready); end
    tests_run++; if (push !== 4'b0100 || data_out !== 6'h21)
      begin tests_failed++; $display("FAIL bp_release_push: push=%b data=%h want 0100/21", push, data_out); end
    tests_run++; if (stall !== 1'b0 || stall_cycles !== 8'd5)
      begin tests_failed++; $display("FAIL bp_release_status: stall=%b cyc=%0d want 0/5", stall, stall_cycles); end
  endtask

  task automatic test_depth_limit();
    for (int k = 0; k < 8; k++) tick(1'b1, 6'(6'h10 + k), 4'b0000, 4'b0000);
    tick(1'b1, 6'h1A, 4'b0000, 4'b0000);
    tests_run++; if (obs_ready !== 1'b1) begin tests_failed++; $display("FAIL depth_ninth_accept: got %b want 1", obs_ready); end
    tests_run++; if (push !== 4'b0010 || data_out !== 6'h17)
      begin tests_failed++; $display("FAIL depth_eighth_push: push=%b data=%h want 0010/17", push, data_out); end
    tick(1'b0, 6'h00, 4'b0000, 4'b0000);
    tests_run++; if (obs_ready !== 1'b0) begin tests_failed++; $display("FAIL depth_full_ready: got %b want 0", obs_ready); end
    tick(1'b0, 6'h00, 4'b0000, 4'b0000);
    tests_run++; if (stall !== 1'b1 || push !== 4'b0000 || dut.cnt[1] !== 4'd8)
      begin tests_failed++; $display("FAIL depth_full: stall=%b push=%b cnt=%0d want 1/0000/8", stall, push, dut.cnt[1]); end
    tick(1'b0, 6'h00, 4'b0000, 4'b0010);
    tests_run++; if (push !== 4'b0000) begin tests_failed++; $display("FAIL depth_pop_cycle_push: got %b want 0000", push); end
    tick(1'b0, 6'h00, 4'b0000, 4'b0000);
    tests_run++; if (push !== 4'b0010 || data_out !== 6'h1A)
      begin tests_failed++; $display("FAIL depth_ninth_push: push=%b data=%h want 0010/1a", push, data_out); end
    tick(1'b0, 6'h00, 4'b0000, 4'b0000);
    tests_run++; if (dut.cnt[1] !== 4'd8) begin tests_failed++; $display("FAIL depth_cnt_back: got %0d want 8", dut.cnt[1]); end
    repeat (8) tick(1'b0, 6'h00, 4'b0000, 4'b0010);
    tests_run++; if (dut.cnt[1] !== 4'd0) begin tests_failed++; $display("FAIL depth_drain: got %0d want 0", dut.cnt[1]); end
  endtask

  task automatic test_simul_underflow();
    tick(1'b1, 6'h2B, 4'b0000, 4'b0000);
    tests_run++; if (dut.cnt[2] !== 4'd1) begin tests_failed++; $display("FAIL sim_pre_cnt: got %0d want 1", dut.cnt[2]); end
    tick(1'b0, 6'h00, 4'b0000, 4'b0000);
    tests_run++; if (push !== 4'b0100) begin tests_failed++; $display("FAIL sim_push: got %b want 0100", push); end
    tick(1'b0, 6'h00, 4'b0000, 4'b0100);
    tests_run++; if (dut.cnt[2] !== 4'd1) begin tests_failed++; $display("FAIL sim_cnt_unchanged: got %0d want 1", dut.cnt[2]); end
    tests_run++; if (underflow_err !== 1'b0) begin tests_failed++; $display("FAIL sim_no_uf: got %b want 0", underflow_err); end
    tick(1'b0, 6'h00, 4'b0000, 4'b1000);
    tests_run++; if (underflow_err !== 1'b1 || dut.cnt[3] !== 4'd0)
      begin tests_failed++; $display("FAIL uf_set: uf=%b cnt3=%0d want 1/0", underflow_err, dut.cnt[3]); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 6'h00, 4'b0000, 4'b0000);
      tests_run++; if (underflow_err !== 1'b1) begin tests_failed++; $display("FAIL uf_sticky[%0d]: got %b want 1", k, underflow_err); end
    end
    tick(1'b0, 6'h00, 4'b0000, 4'b0100);
  endtask

  task automatic test_random();
    logic       v;
    logic [3:0] af, p;
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      af = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      p  = '0;
      for (int i = 0; i < 4; i++) if (m_cnt[i] > 0 && $urandom_range(0, 2) == 0) p[i] = 1'b1;
      tick(v, 6'($urandom), af, p);
      tests_run++; if (obs_ready !== exp_ready) begin tests_failed++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, obs_ready, exp_ready); end
      tests_run++; if (push !== m_push) begin tests_failed++; $display("FAIL rnd_push[%0d]: got %b want %b", n, push, m_push); end
      if (m_push != 4'b0000) begin
        tests_run++; if (data_out !== m_data) begin tests_failed++; $display("FAIL rnd_data[%0d]: got %h want %h", n, data_out, m_data); end
      end
      tests_run++; if (stall !== m_stall || stall_cycles !== 8'(m_stall_cycles))
        begin tests_failed++; $display("FAIL rnd_stall[%0d]: stall=%b cyc=%0d want %b/%0d", n, stall, stall_cycles, m_stall, m_stall_cycles); end
      tests_run++; if (underflow_err !== m_uf) begin tests_failed++; $display("FAIL rnd_uf[%0d]: got %b want %b", n, underflow_err, m_uf); end
      for (int i = 0; i < 4; i++) begin
        tests_run++; if (dut.cnt[i] !== 4'(m_cnt[i])) begin tests_failed++; $display("FAIL rnd_cnt%0d[%0d]: got %0d want %0d", i, n, dut.cnt[i], m_cnt[i]); end
      end
    end
  endtask

  task automatic test_saturate();
    tick(1'b1, 6'h3C, 4'b1000, 4'b0000);
    repeat (300) tick(1'b0, 6'h00, 4'b1000, 4'b0000);
    tests_run++; if (stall !== 1'b1 || stall_cycles !== 8'hFF)
      begin tests_failed++; $display("FAIL sat_cycles: stall=%b cyc=%0d want 1/255", stall, stall_cycles); end
  endtask

  task automatic test_reset_mid_stall();
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_precond: stall=%b want 1", stall); end
    #2;
    reset_L = 1'b0;
    m_reset();
    #1;
    tests_run++; if (push !== 4'b0000 || data_out !== 6'h00 || in_ready !== 1'b0)
      begin tests_failed++; $display("FAIL rst_mid_outputs: push=%b data=%h ready=%b want 0000/00/0", push, data_out, in_ready); end
    tests_run++; if (stall !== 1'b0 || stall_cycles !== 8'd0 || underflow_err !== 1'b0)
      begin tests_failed++; $display("FAIL rst_mid_status: stall=%b cyc=%0d uf=%b want 0/0/0", stall, stall_cycles, underflow_err); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (dut.cnt[i] !== 4'd0) begin tests_failed++; $display("FAIL rst_mid_cnt%0d: got %0d want 0", i, dut.cnt[i]); end
    end
    @(negedge clk);
    reset_L = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 6'h00, 4'b0000, 4'b0000);
      tests_run++; if (push !== 4'b0000 || stall !== 1'b0)
        begin tests_failed++; $display("FAIL rst_mid_no_push[%0d]: push=%b stall=%b want 0000/0", k, push, stall); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_depth_limit();
    test_simul_underflow();
    test_random();
    test_saturate();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
